// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with a start/done handshake.
//
// Software or a control FSM writes a reload value (load_w/load_val), pulses
// start, and receives a one-cycle done pulse when the count reaches zero.
// Used for delay and timeout generation.
//
// Optional feature (macro COUNTDOWN_AUTO_RELOAD_EN): when defined, the
// counter wraps from 1 back to the reload value and stays in RUN, pulsing
// done on every wrap. Only stop or reset leaves RUN. When undefined, a run
// terminates through the one-cycle DONE state.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   asynchronous, active-high reset
//   load_w   in   write strobe, captures load_val into the reload register
//   load_val in   reload value [WIDTH]
//   start    in   begin countdown (level sampled on the rising edge)
//   stop     in   abort countdown (highest priority in RUN)
//   pause    in   hold the count while high
//   q        out  current count [WIDTH], registered
//   busy     out  high while counting, registered
//   done     out  one-cycle pulse at terminal count, registered
//   zero     out  combinational, high when q == 0
module countdown_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_w,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] reload;
  logic [WIDTH-1:0] reload_eff;
  logic [WIDTH-1:0] q_nxt;
  logic             busy_nxt;
  logic             done_nxt;

  // A load on the same edge as start must be seen by that start.
  assign reload_eff = load_w ? load_val : reload;

  assign zero = (q == '0);

  // Reload register is writable in every state; a write during RUN only
  // affects the next start (or the next wrap in auto-reload builds).
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       reload <= '0;
    else if (load_w) reload <= load_val;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      q     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      q     <= q_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    q_nxt     = q;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    case (state)
      // DONE lasts one cycle and then behaves exactly like IDLE, so a start
      // on that edge gives back-to-back runs.
      S_IDLE, S_DONE: begin
        state_nxt = S_IDLE;
        busy_nxt  = 1'b0;
        if (start) begin
          if (reload_eff != '0) begin
            q_nxt     = reload_eff;
            busy_nxt  = 1'b1;
            state_nxt = S_RUN;
          end else begin
            // Zero-length run: straight to DONE without ever being busy.
            q_nxt     = '0;
            done_nxt  = 1'b1;
            state_nxt = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (stop) begin
          state_nxt = S_IDLE;
          busy_nxt  = 1'b0;
        end else if (pause) begin
          q_nxt = q;
        end else if (q > ONE) begin
          q_nxt = q - ONE;
        end else begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
          // Wrap from 1 (or from 0 when the reload is 0) to the stored
          // reload value; stay in RUN.
          q_nxt    = reload;
          done_nxt = 1'b1;
`else
          q_nxt     = '0;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = S_DONE;
`endif
        end
      end
      default: begin
        state_nxt = S_IDLE;
        q_nxt     = '0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule
